pipelined_cla_addsub: RTL and testbench
=======================================

Name: pipelined_cla_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake and status flags. Successor to the fixed 32-bit combinational CLA add/sub used in the ALU path: width and pipeline depth are generic, and the carry chain is split across register stages. Sits between the execute-stage operand mux and writeback/branch-compare logic, and can also serve address generation.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of GROUP*STAGES.
GROUP, 4, bits per lookahead group (group P/G generate, 1-level lookahead across groups within a segment).
STAGES, 2, pipeline register stages (1..4); datapath split into STAGES equal segments of SEG=WIDTH/STAGES bits.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
x  in  WIDTH  operand A
y  in  WIDTH  operand B
sub  in  1  0: x+y; 1: x-y (y inverted, carry-in=1)
sat  in  1  saturation request (used only with the optional feature)
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result
c_out  out  1  carry out of MSB (for sub: 1 = no borrow)
ovf  out  1  signed overflow
zero  out  1  sum == 0
neg  out  1  sum[WIDTH-1]

Behaviour:
- Reset (async assert, sync release on next clk): all stage valid bits 0; out_valid=0; sum, c_out, ovf, zero, neg = 0. in_ready=1 during/after reset. In-flight beats are discarded with no output.
- Transfer on input when in_valid & in_ready; on output when out_valid & out_ready.
- Stage k (0..STAGES-1) adds segment k (bits [SEG*(k+1)-1 : SEG*k]) of x and y^{WIDTH{sub}}, with carry-in = sub for k=0, else the registered carry-out of stage k-1. Within a segment: GROUP-bit groups, per-bit P=x^y, G=x&y, group P/G, lookahead carries across groups (no ripple between groups).
- Lower-segment sums computed earlier are carried forward in the pipeline registers; upper-segment operands and sub are delayed so each segment sees its own beat's carry.
- Latency: exactly STAGES cycles from input transfer to out_valid when not stalled. Throughput 1 beat/cycle.
- Stall: stage k advances iff it is empty or stage k+1 advances; last stage advances iff !out_valid | out_ready. in_ready = stage 0 can advance (combinational from out_ready). No beat is dropped or duplicated; order is preserved. Outputs hold stable while out_valid & !out_ready.
- Flags (from final stage): c_out = carry out of bit WIDTH-1; ovf = (xMSB == y'MSB) & (sumMSB != xMSB), where y' is the post-inversion operand; zero and neg computed on the final (possibly saturated) sum.
- Simultaneous input and output transfer in a full pipeline is allowed; occupancy stays unchanged.
- sat is ignored when the feature is compiled out.
- Illegal parameters (WIDTH % (GROUP*STAGES) != 0, STAGES=0): generation-time error via an invalid generate branch.

Optional Feature:
ADDSUB_SATURATE_EN. When defined: sat travels with the beat. If sat=1 and ovf=1, sum is replaced by 0x7F..F when the true result is positive (x MSB = 0), or 0x80..0 when it is negative. ovf still reports 1 and c_out is unchanged. When undefined: no sat logic or pipeline bits exist; the sat port remains and is ignored. Result is always wrap-around.

Test Plan:
1. WIDTH=32, STAGES=2: x=0xFFFFFFFF, y=1, sub=0 -> sum=0, c_out=1, zero=1, ovf=0, neg=0; out_valid exactly 2 cycles after accept.
2. x=5, y=7, sub=1 -> sum=0xFFFFFFFE, c_out=0, neg=1, ovf=0. Then x=7, y=5, sub=1 -> sum=2, c_out=1.
3. x=0x7FFFFFFF, y=1, sub=0 -> sum=0x80000000, ovf=1, neg=1. With ADDSUB_SATURATE_EN and sat=1 -> sum=0x7FFFFFFF, ovf=1, neg=0.
4. Back-to-back stream of 6 beats with out_ready held 0 for cycles 3-6 -> in_ready drops after 2 beats are buffered (STAGES=2). All 6 results arrive in order with correct values, and outputs stay stable during the stall.
5. Carry across segment boundary: x=0x0000FFFF, y=1 -> sum=0x00010000. Repeat with STAGES=1, 4 and WIDTH=64 (x=0xFFFFFFFFFFFFFFFF, y=1 -> sum 0, c_out 1).
6. Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 immediately (async) with all flags 0, no stale beat emitted afterwards, in_ready=1 the cycle after release.

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: parametrised carry-lookahead add/sub, carry chain split
// into STAGES register stages of SEG = WIDTH/STAGES bits, valid/ready handshake,
// carry/overflow/zero/negative flags.
// Optional build macro ADDSUB_SATURATE_EN: sat travels with the beat and clamps
// an overflowing result to the signed max/min.

// One segment: GROUP-bit lookahead groups, carries into every group are
// expanded as sums of products so no carry ripples from group to group.
module cla_segment #(
    parameter int SEG   = 16,
    parameter int GROUP = 4
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           c_i,
    output logic [SEG-1:0] s_o,
    output logic           c_o
);
    localparam int NG = SEG / GROUP;

    logic [SEG-1:0] p, g, c;
    logic [NG-1:0]  gp, gg;
    logic [NG:0]    gc;
    logic           t;

    // group propagate/generate, lookahead group carries, in-group bit carries
    always_comb begin
        p  = a_i ^ b_i;
        g  = a_i & b_i;
        gp = '0;
        gg = '0;
        gc = '0;
        c  = '0;
        t  = 1'b0;
        for (int j = 0; j < NG; j++) begin
            gp[j] = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
                gp[j] = gp[j] & p[j*GROUP+i];
            end
        end
        for (int j = 0; j <= NG; j++) begin
            gc[j] = c_i;
            for (int n = 0; n < j; n++) gc[j] = gc[j] & gp[n];
            for (int m = 0; m < j; m++) begin
                t = gg[m];
                for (int n = m + 1; n < j; n++) t = t & gp[n];
                gc[j] = gc[j] | t;
            end
        end
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                if (i == 0) c[j*GROUP] = gc[j];
                else        c[j*GROUP+i] = g[j*GROUP+i-1] | (p[j*GROUP+i-1] & c[j*GROUP+i-1]);
            end
        end
        s_o = p ^ c;
        c_o = gc[NG];
    end
endmodule

module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int SEG = WIDTH / ((STAGES < 1) ? 1 : STAGES);
    localparam int L   = STAGES - 1;

    if (STAGES < 1 || STAGES > 4 || (WIDTH % (GROUP * ((STAGES < 1) ? 1 : STAGES))) != 0) begin : g_bad_params
        $error("pipelined_cla_addsub: WIDTH must be a multiple of GROUP*STAGES, STAGES in 1..4");
    end

    // vld_pipe[0] is the incoming beat, vld_pipe[k] the valid of register k;
    // register STAGES is the output register
    logic [STAGES-1:0] vld_q;
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:1]   adv;

    assign vld_pipe  = {vld_q, in_valid};
    assign in_ready  = adv[1];
    assign out_valid = vld_pipe[STAGES];

    // a register may load when it is empty or the register after it drains
    always_comb begin
        logic go;
        go = out_ready | ~vld_pipe[STAGES];
        adv = '0;
        adv[STAGES] = go;
        for (int k = STAGES - 1; k >= 1; k--) begin
            go = go | ~vld_pipe[k];
            adv[k] = go;
        end
    end

    // valid shift register; a bubble moves forward like any beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else begin
            for (int k = 1; k <= STAGES; k++)
                if (adv[k]) vld_q[k-1] <= vld_pipe[k-1];
        end
    end

    // y is inverted once at the input, so only the carry (not sub) has to
    // travel with the beat; each stage consumes the low SEG bits of what
    // remains of the operands and appends its segment sum to the result
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int AW = WIDTH - SEG*k;
        logic [AW-1:0]        a, b;
        logic                 cin, co;
        logic [SEG-1:0]       s;
        logic [SEG*(k+1)-1:0] acc;
`ifdef ADDSUB_SATURATE_EN
        logic                 sat_b;
`endif
        if (k == 0) begin : g_in
            assign a   = x;
            assign b   = y ^ {WIDTH{sub}};
            assign cin = sub;
            assign acc = s;
`ifdef ADDSUB_SATURATE_EN
            assign sat_b = sat;
`endif
        end else begin : g_reg
            logic [AW-1:0]    a_q, b_q;
            logic [SEG*k-1:0] lo_q;
            logic             c_q;
`ifdef ADDSUB_SATURATE_EN
            logic             sat_q;
`endif
            // capture the previous segment's carry, partial sum and upper operands
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    lo_q  <= '0;
                    c_q   <= 1'b0;
`ifdef ADDSUB_SATURATE_EN
                    sat_q <= 1'b0;
`endif
                end else if (adv[k] && vld_pipe[k-1]) begin
                    a_q   <= g_st[k-1].a[AW+SEG-1:SEG];
                    b_q   <= g_st[k-1].b[AW+SEG-1:SEG];
                    lo_q  <= g_st[k-1].acc;
                    c_q   <= g_st[k-1].co;
`ifdef ADDSUB_SATURATE_EN
                    sat_q <= g_st[k-1].sat_b;
`endif
                end
            end
            assign a   = a_q;
            assign b   = b_q;
            assign cin = c_q;
            assign acc = {s, lo_q};
`ifdef ADDSUB_SATURATE_EN
            assign sat_b = sat_q;
`endif
        end

        cla_segment #(.SEG(SEG), .GROUP(GROUP)) u_cla (
            .a_i (a[SEG-1:0]),
            .b_i (b[SEG-1:0]),
            .c_i (cin),
            .s_o (s),
            .c_o (co)
        );
    end

`ifndef ADDSUB_SATURATE_EN
    logic unused_sat;
    assign unused_sat = sat;
`endif

    logic [WIDTH-1:0] res_d;
    logic             ovf_d;

    // signed overflow from operand MSBs, optional clamp to signed max/min
    always_comb begin
        ovf_d = (g_st[L].a[SEG-1] == g_st[L].b[SEG-1]) && (g_st[L].acc[WIDTH-1] != g_st[L].a[SEG-1]);
        res_d = g_st[L].acc;
`ifdef ADDSUB_SATURATE_EN
        if (g_st[L].sat_b && ovf_d)
            res_d = g_st[L].a[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, zero_q, neg_q;

    // output register; holds while the downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (adv[STAGES] && vld_pipe[STAGES-1]) begin
            sum_q  <= res_d;
            cout_q <= g_st[L].co;
            ovf_q  <= ovf_d;
            zero_q <= (res_d == '0);
            neg_q  <= res_d[WIDTH-1];
        end
    end

    assign sum   = sum_q;
    assign c_out = cout_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;
    assign neg   = neg_q;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench: default 32-bit/2-stage instance plus a 64-bit/4-stage and a
// 32-bit/1-stage instance for segment-boundary and latency variants.
module tb_pipelined_cla_addsub;
    logic clk, rst;

    logic        in_valid, in_ready, sub, sat, out_valid, out_ready, c_out, ovf, zero, neg;
    logic [31:0] x, y, sum;

    logic        w_in_valid, w_in_ready, w_sub, w_sat, w_out_valid, w_out_ready, w_c_out, w_ovf, w_zero, w_neg;
    logic [63:0] w_x, w_y, w_sum;

    logic        s_in_valid, s_in_ready, s_sub, s_sat, s_out_valid, s_out_ready, s_c_out, s_ovf, s_zero, s_neg;
    logic [31:0] s_x, s_y, s_sum;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] sx[6], sy[6], ssum[6];
    logic        ssub[6];

    pipelined_cla_addsub #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
        .sub(sub), .sat(sat), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .c_out(c_out), .ovf(ovf), .zero(zero), .neg(neg));

    pipelined_cla_addsub #(.WIDTH(64), .GROUP(4), .STAGES(4)) dut_w64 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .x(w_x), .y(w_y),
        .sub(w_sub), .sat(w_sat), .out_valid(w_out_valid), .out_ready(w_out_ready), .sum(w_sum),
        .c_out(w_c_out), .ovf(w_ovf), .zero(w_zero), .neg(w_neg));

    pipelined_cla_addsub #(.WIDTH(32), .GROUP(4), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .x(s_x), .y(s_y),
        .sub(s_sub), .sat(s_sat), .out_valid(s_out_valid), .out_ready(s_out_ready), .sum(s_sum),
        .c_out(s_c_out), .ovf(s_ovf), .zero(s_zero), .neg(s_neg));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sx[0] = 32'h1;        sy[0] = 32'h2;        ssub[0] = 1'b0; ssum[0] = 32'h3;
        sx[1] = 32'h10;       sy[1] = 32'h1;        ssub[1] = 1'b1; ssum[1] = 32'hF;
        sx[2] = 32'h12345678; sy[2] = 32'h11111111; ssub[2] = 1'b0; ssum[2] = 32'h23456789;
        sx[3] = 32'h0;        sy[3] = 32'h1;        ssub[3] = 1'b1; ssum[3] = 32'hFFFFFFFF;
        sx[4] = 32'h80000000; sy[4] = 32'h80000000; ssub[4] = 1'b0; ssum[4] = 32'h0;
        sx[5] = 32'hAAAAAAAA; sy[5] = 32'h55555555; ssub[5] = 1'b0; ssum[5] = 32'hFFFFFFFF;

        clk = 0; rst = 1;
        in_valid = 0; x = 0; y = 0; sub = 0; sat = 0; out_ready = 1;
        w_in_valid = 0; w_x = 0; w_y = 0; w_sub = 0; w_sat = 0; w_out_ready = 1;
        s_in_valid = 0; s_x = 0; s_y = 0; s_sub = 0; s_sat = 0; s_out_ready = 1;
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst sum", sum, 0);
        chk("rst flags", {c_out, ovf, zero, neg}, 4'b0000);
        chk("rst in_ready", in_ready, 1);
        tick(); tick();
        rst = 0;
        tick();

        // all-ones + 1: wraps to zero with carry, latency 2
        in_valid = 1; x = 32'hFFFFFFFF; y = 32'h1; sub = 0;
        tick();
        in_valid = 0;
        chk("t1 latency1", out_valid, 0);
        tick();
        chk("t1 latency2", out_valid, 1);
        chk("t1 sum", sum, 0);
        chk("t1 flags c/ovf/zero/neg", {c_out, ovf, zero, neg}, 4'b1010);
        tick();
        chk("t1 drained", out_valid, 0);

        // subtraction with and without borrow, back to back
        in_valid = 1; x = 32'h5; y = 32'h7; sub = 1;
        tick();
        x = 32'h7; y = 32'h5; sub = 1;
        tick();
        in_valid = 0; sub = 0;
        chk("t2 5-7 sum", sum, 32'hFFFFFFFE);
        chk("t2 5-7 flags", {c_out, ovf, zero, neg}, 4'b0001);
        tick();
        chk("t2 7-5 sum", sum, 32'h2);
        chk("t2 7-5 flags", {c_out, ovf, zero, neg}, 4'b1000);
        tick();

        // signed overflow, then the same beat with sat requested
        in_valid = 1; x = 32'h7FFFFFFF; y = 32'h1; sub = 0; sat = 0;
        tick();
        sat = 1;
        tick();
        in_valid = 0; sat = 0;
        chk("t3 ovf sum", sum, 32'h80000000);
        chk("t3 ovf flags", {c_out, ovf, zero, neg}, 4'b0101);
        tick();
`ifdef ADDSUB_SATURATE_EN
        chk("t3 sat sum", sum, 32'h7FFFFFFF);
        chk("t3 sat flags", {c_out, ovf, zero, neg}, 4'b0100);
`else
        chk("t3 sat-ignored sum", sum, 32'h80000000);
        chk("t3 sat-ignored flags", {c_out, ovf, zero, neg}, 4'b0101);
`endif
        tick();

        // carry across the 16-bit segment boundary
        in_valid = 1; x = 32'h0000FFFF; y = 32'h1;
        tick();
        in_valid = 0;
        tick();
        chk("t5 boundary sum", sum, 32'h00010000);
        chk("t5 boundary c_out", c_out, 0);
        tick();

        // six-beat stream, downstream stalls in cycles 3..6
        for (int n = 1; n <= 13; n++) begin
            int bi;
            int ei;
            out_ready = (n >= 3 && n <= 6) ? 1'b0 : 1'b1;
            bi = (n == 1) ? 0 : (n == 2) ? 1 : (n <= 7) ? 2 : (n <= 10) ? n - 5 : -1;
            if (bi >= 0) begin
                in_valid = 1; x = sx[bi]; y = sy[bi]; sub = ssub[bi];
            end else begin
                in_valid = 0; sub = 0;
            end
            #1;
            chk($sformatf("t4 in_ready c%0d", n), in_ready, (n >= 3 && n <= 6) ? 1'b0 : 1'b1);
            if (n <= 2 || n == 13) begin
                chk($sformatf("t4 idle c%0d", n), out_valid, 0);
            end else begin
                ei = (n <= 7) ? 0 : n - 7;
                chk($sformatf("t4 out_valid c%0d", n), out_valid, 1);
                chk($sformatf("t4 sum c%0d", n), sum, ssum[ei]);
            end
            tick();
        end
        out_ready = 1;

        // reset with two beats in flight
        in_valid = 1; x = 32'h5; y = 32'h7; sub = 0;
        tick();
        x = 32'h100; y = 32'h23;
        tick();
        in_valid = 0;
        chk("t6 pre-reset sum", sum, 32'hC);
        rst = 1;
        #1;
        chk("t6 async out_valid", out_valid, 0);
        chk("t6 async sum", sum, 0);
        chk("t6 async flags", {c_out, ovf, zero, neg}, 4'b0000);
        chk("t6 in_ready in reset", in_ready, 1);
        tick();
        rst = 0;
        #1;
        chk("t6 in_ready after release", in_ready, 1);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("t6 no stale beat %0d", n), out_valid, 0);
        end

        // 64-bit, 4 stages: latency 4, multi-segment carries
        w_in_valid = 1; w_x = 64'hFFFFFFFFFFFFFFFF; w_y = 64'h1;
        tick();
        w_in_valid = 0;
        chk("w64 latency1", w_out_valid, 0);
        tick();
        chk("w64 latency2", w_out_valid, 0);
        tick();
        chk("w64 latency3", w_out_valid, 0);
        tick();
        chk("w64 latency4", w_out_valid, 1);
        chk("w64 ones+1 sum", w_sum, 64'h0);
        chk("w64 ones+1 c/zero", {w_c_out, w_zero}, 2'b11);
        tick();
        w_in_valid = 1; w_x = 64'h00000000FFFFFFFF; w_y = 64'h1;
        tick();
        w_in_valid = 0;
        tick(); tick(); tick();
        chk("w64 boundary sum", w_sum, 64'h0000000100000000);
        chk("w64 boundary c_out", w_c_out, 0);
        tick();

        // single-stage: latency 1
        s_in_valid = 1; s_x = 32'h0000FFFF; s_y = 32'h1;
        tick();
        s_in_valid = 0;
        chk("s1 latency1", s_out_valid, 1);
        chk("s1 boundary sum", s_sum, 32'h00010000);
        tick();
        chk("s1 drained", s_out_valid, 0);
        s_in_valid = 1; s_x = 32'h3; s_y = 32'h5; s_sub = 1;
        tick();
        s_in_valid = 0; s_sub = 0;
        chk("s1 3-5 sum", s_sum, 32'hFFFFFFFE);
        chk("s1 3-5 c/neg", {s_c_out, s_neg}, 2'b01);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
